// File: rtl/inst_mem_loader_if.sv
// Loader-side bus: session control, byte stream handshake and instruction-memory write port.
interface inst_mem_loader_if #(
    parameter int unsigned ADDR_WIDTH = 12
);
    logic                  start_i;
    logic [ADDR_WIDTH:0]   len_i;
    logic                  byte_valid_i;
    logic [7:0]            byte_data_i;
    logic                  byte_ready_o;
    logic                  mem_we_o;
    logic [31:0]           mem_waddr_o;
    logic [31:0]           mem_wdata_o;
    logic                  cpu_hold_o;
    logic                  busy_o;
    logic                  done_o;
    logic                  err_o;

    modport master (
        output start_i, len_i, byte_valid_i, byte_data_i,
        input  byte_ready_o, mem_we_o, mem_waddr_o, mem_wdata_o,
        input  cpu_hold_o, busy_o, done_o, err_o
    );

    modport slave (
        input  start_i, len_i, byte_valid_i, byte_data_i,
        output byte_ready_o, mem_we_o, mem_waddr_o, mem_wdata_o,
        output cpu_hold_o, busy_o, done_o, err_o
    );
endinterface

// File: rtl/inst_mem_loader.sv
// Byte-stream program loader for instruction memory; holds the core in reset while loading.
// Optional trailing checksum byte is enabled by defining LOADER_CHECKSUM_EN.
module inst_mem_loader #(
    parameter int unsigned ADDR_WIDTH = 12,
    parameter logic [31:0] BASE_ADDR  = 32'h0000_0000
) (
    input logic              clk,
    input logic              rst,
    inst_mem_loader_if.slave bus
);
    localparam int unsigned LW = ADDR_WIDTH + 1;
    localparam logic [LW-1:0] MAX_LEN = LW'(1) << ADDR_WIDTH;

    typedef enum logic [2:0] {
        S_IDLE,
        S_RECV,
        S_WRITE,
`ifdef LOADER_CHECKSUM_EN
        S_CHECK,
`endif
        S_DONE
    } state_t;

    state_t          state;
    logic [LW-1:0]   len_q;
    logic [LW-1:0]   idx;
    logic [1:0]      byte_cnt;
    logic [23:0]     word_lo;
`ifdef LOADER_CHECKSUM_EN
    logic [7:0]      csum;
`endif

    // Session FSM with all outputs registered.
    always_ff @(posedge clk) begin
        if (rst) begin
            state            <= S_IDLE;
            len_q            <= '0;
            idx              <= '0;
            byte_cnt         <= '0;
            word_lo          <= '0;
`ifdef LOADER_CHECKSUM_EN
            csum             <= '0;
`endif
            bus.byte_ready_o <= 1'b0;
            bus.mem_we_o     <= 1'b0;
            bus.mem_waddr_o  <= BASE_ADDR;
            bus.mem_wdata_o  <= '0;
            bus.cpu_hold_o   <= 1'b0;
            bus.busy_o       <= 1'b0;
            bus.done_o       <= 1'b0;
            bus.err_o        <= 1'b0;
        end else begin
            bus.mem_we_o <= 1'b0;
            bus.done_o   <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (bus.start_i) begin
                        if (bus.len_i > MAX_LEN) begin
                            bus.err_o <= 1'b1;
                        end else begin
                            len_q          <= bus.len_i;
                            idx            <= '0;
                            byte_cnt       <= '0;
                            bus.err_o      <= 1'b0;
                            bus.busy_o     <= 1'b1;
                            bus.cpu_hold_o <= 1'b1;
`ifdef LOADER_CHECKSUM_EN
                            csum           <= '0;
`endif
                            if (bus.len_i == '0) begin
`ifdef LOADER_CHECKSUM_EN
                                state            <= S_CHECK;
                                bus.byte_ready_o <= 1'b1;
`else
                                state            <= S_DONE;
                                bus.done_o       <= 1'b1;
`endif
                            end else begin
                                state            <= S_RECV;
                                bus.byte_ready_o <= 1'b1;
                            end
                        end
                    end
                end

                S_RECV: begin
                    if (bus.byte_valid_i && bus.byte_ready_o) begin
                        byte_cnt <= byte_cnt + 2'd1;
`ifdef LOADER_CHECKSUM_EN
                        csum     <= csum + bus.byte_data_i;
`endif
                        case (byte_cnt)
                            2'd0: word_lo[7:0]   <= bus.byte_data_i;
                            2'd1: word_lo[15:8]  <= bus.byte_data_i;
                            2'd2: word_lo[23:16] <= bus.byte_data_i;
                            default: begin
                                // Fourth byte completes the word; launch the write directly.
                                state            <= S_WRITE;
                                bus.byte_ready_o <= 1'b0;
                                bus.mem_we_o     <= 1'b1;
                                bus.mem_waddr_o  <= BASE_ADDR + (32'(idx) << 2);
                                bus.mem_wdata_o  <= {bus.byte_data_i, word_lo};
                            end
                        endcase
                    end
                end

                S_WRITE: begin
                    idx <= idx + LW'(1);
                    if (idx + LW'(1) == len_q) begin
`ifdef LOADER_CHECKSUM_EN
                        state            <= S_CHECK;
                        bus.byte_ready_o <= 1'b1;
`else
                        state            <= S_DONE;
                        bus.done_o       <= ~bus.err_o;
`endif
                    end else begin
                        state            <= S_RECV;
                        bus.byte_ready_o <= 1'b1;
                    end
                end

`ifdef LOADER_CHECKSUM_EN
                S_CHECK: begin
                    if (bus.byte_valid_i && bus.byte_ready_o) begin
                        state            <= S_DONE;
                        bus.byte_ready_o <= 1'b0;
                        if (bus.byte_data_i == csum) begin
                            bus.done_o <= 1'b1;
                        end else begin
                            bus.err_o  <= 1'b1;
                        end
                    end
                end
`endif

                S_DONE: begin
                    state          <= S_IDLE;
                    bus.busy_o     <= 1'b0;
                    bus.cpu_hold_o <= 1'b0;
                end

                default: state <= S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_inst_mem_loader.sv
// Directed self-checking bench for inst_mem_loader (ADDR_WIDTH=4, non-zero BASE_ADDR).
module tb_inst_mem_loader;
    localparam int unsigned AW   = 4;
    localparam int unsigned LW   = AW + 1;
    localparam logic [31:0] BASE = 32'h0000_1000;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    inst_mem_loader_if #(.ADDR_WIDTH(AW)) bus ();

    inst_mem_loader #(.ADDR_WIDTH(AW), .BASE_ADDR(BASE)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int n_checks  = 0;
    int n_errors  = 0;
    int we_cnt    = 0;
    int done_cnt  = 0;
    int xfer_cnt  = 0;
    int hold_viol = 0;
    logic [31:0] wr_addr_q[$];
    logic [31:0] wr_data_q[$];

    // Observe writes, done pulses and byte transfers mid-cycle.
    always @(negedge clk) begin
        if (!rst) begin
            if (bus.mem_we_o) begin
                we_cnt++;
                wr_addr_q.push_back(bus.mem_waddr_o);
                wr_data_q.push_back(bus.mem_wdata_o);
                if (!bus.cpu_hold_o) hold_viol++;
            end
            if (bus.done_o) begin
                done_cnt++;
                if (!bus.cpu_hold_o) hold_viol++;
            end
            if (bus.byte_valid_i && bus.byte_ready_o) xfer_cnt++;
        end
    end

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_log();
        we_cnt = 0; done_cnt = 0; xfer_cnt = 0; hold_viol = 0;
        wr_addr_q.delete();
        wr_data_q.delete();
    endtask

    task automatic check_reset_outputs(input string pfx);
        check({pfx, "_ready"}, 32'(bus.byte_ready_o), 32'd0);
        check({pfx, "_we"},    32'(bus.mem_we_o),     32'd0);
        check({pfx, "_waddr"}, bus.mem_waddr_o,       BASE);
        check({pfx, "_wdata"}, bus.mem_wdata_o,       32'd0);
        check({pfx, "_hold"},  32'(bus.cpu_hold_o),   32'd0);
        check({pfx, "_busy"},  32'(bus.busy_o),       32'd0);
        check({pfx, "_done"},  32'(bus.done_o),       32'd0);
        check({pfx, "_err"},   32'(bus.err_o),        32'd0);
    endtask

    task automatic start_load(input int len);
        bus.start_i = 1'b1;
        bus.len_i   = LW'(len);
        tick();
        bus.start_i = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] b, input int gap);
        bit rdy;
        int n;
        n = 0;
        bus.byte_valid_i = 1'b1;
        bus.byte_data_i  = b;
        do begin
            @(negedge clk);
            rdy = bus.byte_ready_o;
            @(posedge clk);
            n++;
        end while (!rdy && n < 50);
        #1;
        bus.byte_valid_i = 1'b0;
        if (!rdy) check("byte_accept_timeout", 32'd0, 32'd1);
        repeat (gap) tick();
    endtask

    task automatic send_word(input logic [31:0] w, input int gap);
        for (int k = 0; k < 4; k++) send_byte(w[8*k +: 8], gap);
    endtask

    function automatic logic [7:0] byte_sum(input logic [31:0] words[$]);
        logic [7:0] s = 8'h00;
        foreach (words[i]) s = s + words[i][7:0] + words[i][15:8] + words[i][23:16] + words[i][31:24];
        return s;
    endfunction

    task automatic send_checksum(input logic [7:0] c, input int gap);
`ifdef LOADER_CHECKSUM_EN
        send_byte(c, gap);
`else
        if (c == 8'h00 && gap < 0) send_byte(c, 0);
`endif
    endtask

    task automatic wait_done(output bit seen);
        seen = 1'b0;
        for (int i = 0; i < 40; i++) begin
            if (bus.done_o) begin
                seen = 1'b1;
                break;
            end
            tick();
        end
    endtask

    task automatic check_writes(input string pfx, input logic [31:0] words[$]);
        check({pfx, "_nwr"}, 32'(wr_addr_q.size()), 32'(words.size()));
        foreach (words[i]) begin
            if (i < wr_addr_q.size()) begin
                check({pfx, "_addr"}, wr_addr_q[i], BASE + 32'(4 * i));
                check({pfx, "_data"}, wr_data_q[i], words[i]);
            end
        end
    endtask

    task automatic finish_session(input string pfx);
        bit seen;
        wait_done(seen);
        check({pfx, "_done_seen"}, 32'(seen), 32'd1);
        check({pfx, "_hold_at_done"}, 32'(bus.cpu_hold_o), 32'd1);
        tick();
        check({pfx, "_done_pulse"}, 32'(bus.done_o), 32'd0);
        check({pfx, "_hold_fall"}, 32'(bus.cpu_hold_o), 32'd0);
        check({pfx, "_busy_fall"}, 32'(bus.busy_o), 32'd0);
        check({pfx, "_ndone"}, 32'(done_cnt), 32'd1);
        check({pfx, "_hold_span"}, 32'(hold_viol), 32'd0);
    endtask

    logic [31:0] prog[$];
    logic [31:0] big[$];
    bit          seen;
    int          cks_bytes;

    initial begin
`ifdef LOADER_CHECKSUM_EN
        cks_bytes = 1;
`else
        cks_bytes = 0;
`endif
        bus.start_i      = 1'b0;
        bus.len_i        = '0;
        bus.byte_valid_i = 1'b0;
        bus.byte_data_i  = '0;

        // Reset and idle
        rst = 1'b1;
        tick(); tick();
        rst = 1'b0;
        repeat (10) tick();
        check_reset_outputs("idle");
        check("idle_no_write", 32'(we_cnt), 32'd0);

        // Two-word load, back-to-back bytes
        prog = '{32'h0000_0013, 32'h0010_0093};
        clear_log();
        start_load(2);
        check("start_busy",  32'(bus.busy_o),       32'd1);
        check("start_hold",  32'(bus.cpu_hold_o),   32'd1);
        check("start_ready", 32'(bus.byte_ready_o), 32'd1);
        send_word(prog[0], 0);
        check("w0_we",    32'(bus.mem_we_o),     32'd1);
        check("w0_addr",  bus.mem_waddr_o,       BASE);
        check("w0_data",  bus.mem_wdata_o,       32'h0000_0013);
        check("w0_ready", 32'(bus.byte_ready_o), 32'd0);
        send_word(prog[1], 0);
        check("w1_we",    32'(bus.mem_we_o),     32'd1);
        send_checksum(byte_sum(prog), 0);
        finish_session("b2b");
        check_writes("b2b", prog);

        // Same load with a stalling source
        clear_log();
        start_load(2);
        send_word(prog[0], 1);
        send_word(prog[1], 1);
        send_checksum(byte_sum(prog), 1);
        finish_session("gap");
        check_writes("gap", prog);
        check("gap_xfers", 32'(xfer_cnt), 32'(8 + cks_bytes));

        // Oversize length, then recovery
        clear_log();
        start_load(17);
        check("big_err",   32'(bus.err_o),        32'd1);
        check("big_busy",  32'(bus.busy_o),       32'd0);
        check("big_ready", 32'(bus.byte_ready_o), 32'd0);
        repeat (3) tick();
        check("big_nodone", 32'(done_cnt), 32'd0);
        check("big_stay",   32'(bus.busy_o), 32'd0);
        prog = '{32'h7856_3412};
        start_load(1);
        check("rec_err_clr", 32'(bus.err_o),  32'd0);
        check("rec_busy",    32'(bus.busy_o), 32'd1);
        send_word(prog[0], 0);
        send_checksum(byte_sum(prog), 0);
        finish_session("rec");
        check_writes("rec", prog);

        // Reset in the middle of the second word
        clear_log();
        start_load(2);
        send_word(32'hAABB_CCDD, 0);
        send_byte(8'h11, 0);
        send_byte(8'h22, 0);
        rst = 1'b1;
        tick();
        check_reset_outputs("midrst");
        rst = 1'b0;
        tick();
        check("midrst_nwr",  32'(we_cnt), 32'd1);
        check("midrst_data", (wr_data_q.size() > 0) ? wr_data_q[0] : 32'hx, 32'hAABB_CCDD);
        clear_log();
        prog = '{32'h0000_0513};
        start_load(1);
        send_word(prog[0], 0);
        send_checksum(byte_sum(prog), 0);
        finish_session("fresh");
        check_writes("fresh", prog);

        // Zero-length session
        clear_log();
        start_load(0);
        check("len0_busy", 32'(bus.busy_o), 32'd1);
        send_checksum(8'h00, 0);
        finish_session("len0");
        check("len0_nwr", 32'(we_cnt), 32'd0);

        // Full-depth load fills every word
        clear_log();
        big.delete();
        for (int i = 0; i < 16; i++) big.push_back({8'(4*i+3), 8'(4*i+2), 8'(4*i+1), 8'(4*i)});
        start_load(16);
        check("full_err", 32'(bus.err_o), 32'd0);
        foreach (big[i]) send_word(big[i], 0);
        send_checksum(byte_sum(big), 0);
        finish_session("full");
        check_writes("full", big);

`ifdef LOADER_CHECKSUM_EN
        // Checksum accepted and rejected
        clear_log();
        start_load(1);
        send_word(32'h0403_0201, 0);
        send_byte(8'h0A, 0);
        finish_session("cks_ok");
        check("cks_ok_err", 32'(bus.err_o), 32'd0);
        clear_log();
        start_load(1);
        send_word(32'h0403_0201, 0);
        send_byte(8'h0B, 0);
        wait_done(seen);
        check("cks_bad_nodone", 32'(seen), 32'd0);
        check("cks_bad_err",    32'(bus.err_o), 32'd1);
        check("cks_bad_idle",   32'(bus.busy_o), 32'd0);
        check("cks_bad_ndone",  32'(done_cnt), 32'd0);
`endif

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
